// File: rtl/arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and SDRAM address width.
package arb_pkg;

  localparam int SD_AW = 25;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_WAIT,
    RD,
    RD_WAIT
  } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Counts cycles spent waiting for an SDRAM completion; flags the TIMEOUT-th waiting cycle.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM byte port between ROM download writes and gfx reads, with a
// one-byte write buffer, a one-entry read cache and a command watchdog.
module sdram_port_arbiter
  import arb_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter int         GFX_AW    = 19,
  parameter int         TIMEOUT   = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [SD_AW-1:0]  ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic [GFX_AW-1:0] gfx_addr,
  input  logic              gfx_read,
  output logic [7:0]        gfx_data,
  output logic              gfx_valid,
  output logic [SD_AW-1:0]  sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [7:0]        sd_dout,
  input  logic              sd_ready,
  output logic              sd_timeout
);

  arb_state_t state, state_nx;

  logic              buf_full;
  logic [SD_AW-1:0]  buf_addr;
  logic [7:0]        buf_data;
  logic              rd_pend;
  logic [GFX_AW-1:0] rd_addr;
  logic              tag_vld;
  logic [GFX_AW-1:0] tag;

  logic wr_acc, rd_acc, cap_hit, pend_hit;
  logic issue_wr, issue_rd, wr_done, rd_done, expired, abort;

  assign wr_acc = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX) && !buf_full;
  // A read arriving with an accepted write is kept; otherwise downloads mute the gfx side.
  assign rd_acc = gfx_read && (!ioctl_download || wr_acc);

  assign wr_done = (state == WR_WAIT) && sd_ready;
  assign rd_done = (state == RD_WAIT) && sd_ready;
  assign abort   = expired && !sd_ready;

  // No hit while a fill is landing: the tag and gfx_data are about to change.
  assign cap_hit  = rd_acc && tag_vld && (gfx_addr == tag) && !wr_acc && !rd_done;
  assign pend_hit = (state == IDLE) && rd_pend && !buf_full && !rd_acc
                    && tag_vld && (rd_addr == tag);

  assign issue_wr = (state == IDLE) && buf_full;
  assign issue_rd = (state == IDLE) && !buf_full && rd_pend && !pend_hit && !rd_acc;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (issue_wr)      state_nx = WR;
        else if (issue_rd) state_nx = RD;
      end
      WR:      state_nx = WR_WAIT;
      RD:      state_nx = RD_WAIT;
      WR_WAIT: if (sd_ready || expired) state_nx = IDLE;
      RD_WAIT: if (sd_ready || expired) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sd_we      = (state == WR);
  assign sd_rd      = (state == RD);
  assign ioctl_wait = buf_full;

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (sd_we || sd_rd),
    .en      ((state == WR_WAIT) || (state == RD_WAIT)),
    .expired (expired)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      buf_full   <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      rd_pend    <= 1'b0;
      rd_addr    <= '0;
      tag_vld    <= 1'b0;
      tag        <= '0;
      sd_addr    <= '0;
      sd_din     <= '0;
      gfx_data   <= 8'h00;
      gfx_valid  <= 1'b0;
      sd_timeout <= 1'b0;
    end else begin
      state <= state_nx;

      if (wr_acc) begin
        buf_full <= 1'b1;
        buf_addr <= ioctl_addr;
        buf_data <= ioctl_dout;
      end else if (wr_done || ((state == WR_WAIT) && abort)) begin
        buf_full <= 1'b0;
      end

      if (rd_acc) begin
        rd_pend <= !cap_hit;
        rd_addr <= gfx_addr;
      end else if (pend_hit || issue_rd) begin
        rd_pend <= 1'b0;
      end

      if (issue_wr) begin
        sd_addr <= buf_addr;
        sd_din  <= buf_data;
      end else if (issue_rd) begin
        sd_addr <= {{(SD_AW - GFX_AW){1'b0}}, rd_addr};
      end

      // A fill that completes behind a buffered write may already be stale.
      if (wr_acc) begin
        tag_vld <= 1'b0;
      end else if (rd_done && !buf_full) begin
        tag_vld <= 1'b1;
        tag     <= sd_addr[GFX_AW-1:0];
      end

      gfx_valid <= rd_done || cap_hit || pend_hit;
      if (rd_done) gfx_data <= sd_dout;

      if (abort) sd_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: table-driven transactions scored against
// expected SDRAM commands and gfx results, plus hand sequences for timing corners.
module tb_sdram_port_arbiter;

  localparam int TO = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait;
  logic [18:0] gfx_addr;
  logic        gfx_read;
  logic [7:0]  gfx_data;
  logic        gfx_valid;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din, sd_dout;
  logic        sd_we, sd_rd, sd_ready, sd_timeout;

  sdram_port_arbiter #(.ROM_INDEX(8'd0), .GFX_AW(19), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .gfx_addr(gfx_addr), .gfx_read(gfx_read), .gfx_data(gfx_data), .gfx_valid(gfx_valid),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_dout(sd_dout), .sd_ready(sd_ready), .sd_timeout(sd_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          we;
    logic [24:0] addr;
    logic [7:0]  din;
  } cmd_t;

  typedef struct {
    bit          is_wr;
    bit          dl;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    int          lat;
    bit          exp_cmd;
    bit          exp_wait;
    bit          exp_valid;
    logic [7:0]  exp_gd;
  } vec_t;

  cmd_t       cmdq[$];
  logic [7:0] gfxq[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mem[int];
  bit         resp_en = 1'b1;
  int         resp_lat = 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Scoreboard: every SDRAM command and gfx result is matched against the queues in order.
  always @(negedge clk_sys) begin
    if (sd_we || sd_rd) begin
      if (cmdq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_cmd: we=%0b rd=%0b addr=%0h required none", sd_we, sd_rd, sd_addr);
      end else begin
        cmd_t e;
        e = cmdq.pop_front();
        chk("cmd_we", {30'd0, sd_we, sd_rd}, e.we ? 32'd2 : 32'd1);
        chk("cmd_addr", {7'd0, sd_addr}, {7'd0, e.addr});
        if (e.we) chk("cmd_din", {24'd0, sd_din}, {24'd0, e.din});
      end
    end
    if (gfx_valid) begin
      if (gfxq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_gfx_valid: data=%0h required no pulse", gfx_data);
      end else begin
        logic [7:0] d;
        d = gfxq.pop_front();
        chk("gfx_data", {24'd0, gfx_data}, {24'd0, d});
      end
    end
  end

  // SDRAM controller model: completes a command resp_lat cycles after it is issued.
  initial begin
    int          r_cnt;
    bit          r_rd;
    logic [24:0] r_addr;
    r_cnt = 0; r_rd = 1'b0; r_addr = '0;
    sd_ready = 1'b0;
    sd_dout  = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      sd_ready = 1'b0;
      if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0) begin
          sd_ready = 1'b1;
          if (r_rd) sd_dout = mem.exists(int'(r_addr)) ? mem[int'(r_addr)] : (r_addr[7:0] ^ 8'h3C);
        end
      end
      if (resp_en && (sd_we || sd_rd)) begin
        r_cnt  = resp_lat;
        r_rd   = sd_rd;
        r_addr = sd_addr;
        if (sd_we) mem[int'(sd_addr)] = sd_din;
      end
    end
  end

  task automatic drain(input int budget);
    int k = 0;
    while ((cmdq.size() != 0 || gfxq.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("cmds_outstanding", cmdq.size(), 0);
    chk("gfx_outstanding", gfxq.size(), 0);
    cmdq.delete();
    gfxq.delete();
  endtask

  task automatic do_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    resp_lat = v.lat;
    if (v.exp_cmd) cmdq.push_back('{we: v.is_wr, addr: v.addr, din: v.data});
    if (v.exp_valid) gfxq.push_back(v.exp_gd);
    if (v.is_wr) begin
      do_write(v.idx, v.addr, v.data);
      @(negedge clk_sys);
      chk("vec_ioctl_wait", {31'd0, ioctl_wait}, {31'd0, v.exp_wait});
      tick();
      ioctl_download = 1'b0;
    end else begin
      ioctl_download = v.dl;
      gfx_read = 1'b1;
      gfx_addr = v.addr[18:0];
      tick();
      gfx_read = 1'b0;
      ioctl_download = 1'b0;
    end
    drain(200);
    chk("vec_gfx_data_held", {24'd0, gfx_data}, {24'd0, v.exp_gd});
  endtask

  initial begin
    vec_t vt[11];
    int   n;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int   n;
    vt[0]  = '{1'b1, 1'b1, 8'd254, 25'h20,    8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 8'd0,   25'h1234,  8'h00, 2, 1'b1, 1'b0, 1'b1, 8'h5C};
    vt[2]  = '{1'b0, 1'b0, 8'd0,   25'h1234,  8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h5C};
    vt[3]  = '{1'b1, 1'b1, 8'd0,   25'h777,   8'h3E, 1, 1'b1, 1'b1, 1'b0, 8'h5C};
    vt[4]  = '{1'b0, 1'b0, 8'd0,   25'h1234,  8'h00, 2, 1'b1, 1'b0, 1'b1, 8'h5C};
    vt[5]  = '{1'b0, 1'b0, 8'd0,   25'h777,   8'h00, 3, 1'b1, 1'b0, 1'b1, 8'h3E};
    vt[6]  = '{1'b0, 1'b0, 8'd0,   25'h777,   8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h3E};
    vt[7]  = '{1'b1, 1'b1, 8'd1,   25'h777,   8'h99, 1, 1'b0, 1'b0, 1'b0, 8'h3E};
    vt[8]  = '{1'b0, 1'b0, 8'd0,   25'h777,   8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h3E};
    vt[9]  = '{1'b0, 1'b0, 8'd0,   25'h7FFFF, 8'h00, 4, 1'b1, 1'b0, 1'b1, 8'hC3};
    vt[10] = '{1'b0, 1'b1, 8'd0,   25'h777,   8'h00, 1, 1'b0, 1'b0, 1'b0, 8'hC3};

    mem[32'h1234]  = 8'h5C;
    mem[32'h7FFFF] = 8'hC3;

    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = 8'h00; gfx_addr = '0; gfx_read = 1'b0;
    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst_ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_gfx_valid", {31'd0, gfx_valid}, 32'd0);
    chk("rst_sd_we", {31'd0, sd_we}, 32'd0);
    chk("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
    chk("rst_sd_timeout", {31'd0, sd_timeout}, 32'd0);
    chk("rst_gfx_data", {24'd0, gfx_data}, 32'd0);
    chk("rst_sd_addr", {7'd0, sd_addr}, 32'd0);
    chk("rst_sd_din", {24'd0, sd_din}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Download write: ioctl_wait spans capture through completion (lat 5 -> 7 cycles).
    resp_lat = 5;
    cmdq.push_back('{we: 1'b1, addr: 25'h10, din: 8'hA5});
    do_write(8'd0, 25'h10, 8'hA5);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) break;
      n++;
    end
    chk("wait_high_cycles", n, 7);
    ioctl_download = 1'b0;
    drain(50);

    for (int i = 0; i < 11; i++) apply(vt[i]);

    // Write and read captured together: write first, read still re-fetches.
    resp_lat = 2;
    cmdq.push_back('{we: 1'b1, addr: 25'h100, din: 8'h42});
    cmdq.push_back('{we: 1'b0, addr: 25'h7FFFF, din: 8'h00});
    gfxq.push_back(8'hC3);
    gfx_addr = 19'h7FFFF;
    gfx_read = 1'b1;
    do_write(8'd0, 25'h100, 8'h42);
    gfx_read = 1'b0;
    ioctl_download = 1'b0;
    drain(100);
    gfxq.push_back(8'hC3);
    gfx_read = 1'b1; tick(); gfx_read = 1'b0;
    drain(50);
    cmdq.push_back('{we: 1'b1, addr: 25'h101, din: 8'h24});
    do_write(8'd0, 25'h101, 8'h24);
    ioctl_download = 1'b0;
    drain(50);
    cmdq.push_back('{we: 1'b0, addr: 25'h7FFFF, din: 8'h00});
    gfxq.push_back(8'hC3);
    gfx_read = 1'b1; tick(); gfx_read = 1'b0;
    drain(50);

    // Miss latency (3 + controller latency 1) then hit latency (1), counted from the read cycle.
    resp_lat = 1;
    cmdq.push_back('{we: 1'b0, addr: 25'h42, din: 8'h00});
    gfxq.push_back(8'h42 ^ 8'h3C);
    gfx_addr = 19'h42;
    gfx_read = 1'b1; tick(); gfx_read = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      n++;
      if (gfx_valid) break;
    end
    chk("miss_latency", n, 4);
    drain(20);
    gfxq.push_back(8'h42 ^ 8'h3C);
    gfx_read = 1'b1; tick(); gfx_read = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      n++;
      if (gfx_valid) break;
    end
    chk("hit_latency", n, 1);
    drain(20);

    // Controller never answers: watchdog aborts the write after TO waiting cycles.
    resp_en = 1'b0;
    cmdq.push_back('{we: 1'b1, addr: 25'h55, din: 8'h66});
    do_write(8'd0, 25'h55, 8'h66);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      n++;
      if (sd_timeout) break;
    end
    chk("timeout_cycles", n, TO + 3);
    chk("timeout_flag", {31'd0, sd_timeout}, 32'd1);
    chk("timeout_wait_low", {31'd0, ioctl_wait}, 32'd0);
    tick();
    ioctl_download = 1'b0;
    resp_en = 1'b1;
    resp_lat = 1;
    cmdq.push_back('{we: 1'b0, addr: 25'h1234, din: 8'h00});
    gfxq.push_back(8'h5C);
    gfx_addr = 19'h1234;
    gfx_read = 1'b1; tick(); gfx_read = 1'b0;
    drain(50);
    chk("timeout_sticky", {31'd0, sd_timeout}, 32'd1);

    // Reset while a read is in flight; its late completion must be ignored.
    resp_lat = 6;
    cmdq.push_back('{we: 1'b0, addr: 25'h4321, din: 8'h00});
    gfx_addr = 19'h4321;
    gfx_read = 1'b1; tick(); gfx_read = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (12) tick();
    @(negedge clk_sys);
    chk("post_rst_gfx_data", {24'd0, gfx_data}, 32'd0);
    chk("post_rst_sd_addr", {7'd0, sd_addr}, 32'd0);
    chk("post_rst_sd_din", {24'd0, sd_din}, 32'd0);
    chk("post_rst_timeout", {31'd0, sd_timeout}, 32'd0);
    chk("post_rst_ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("post_rst_gfx_valid", {31'd0, gfx_valid}, 32'd0);
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
